// File: rtl/i2c_command_scheduler_if.sv
// ----------------------------------------------------------------------------
// i2c_command_scheduler_if
//   Groups the command scheduler's host-side and transmitter-side signals.
//   master : the scheduler itself (drives start/ack/done/status, reads
//            requests and transmitter completion)
//   slave  : the environment (host requesters and the I2C transmitter)
//
//   init_go          host -> sched   pulse: (re)start the startup table
//   init_done        sched -> host   startup table finished
//   special_req      host -> sched   level: special write requested
//   special_register host -> sched   register address of special write
//   special_data     host -> sched   data word of special write
//   special_ack      sched -> host   pulse: special request accepted
//   special_done     sched -> host   pulse: accepted special write finished
//   i2c_start        sched -> xmit   pulse: send i2c_register/i2c_data
//   i2c_register     sched -> xmit   register byte of current command
//   i2c_data         sched -> xmit   data word of current command
//   i2c_done         xmit -> sched   pulse: STOP sent
//   timeout_error    sched -> host   sticky: a command timed out
// ----------------------------------------------------------------------------
interface i2c_command_scheduler_if;
    logic        init_go;
    logic        init_done;
    logic        special_req;
    logic [7:0]  special_register;
    logic [15:0] special_data;
    logic        special_ack;
    logic        special_done;
    logic        i2c_start;
    logic [7:0]  i2c_register;
    logic [15:0] i2c_data;
    logic        i2c_done;
    logic        timeout_error;

    modport master (
        input  init_go,
        input  special_req,
        input  special_register,
        input  special_data,
        input  i2c_done,
        output init_done,
        output special_ack,
        output special_done,
        output i2c_start,
        output i2c_register,
        output i2c_data,
        output timeout_error
    );

    modport slave (
        output init_go,
        output special_req,
        output special_register,
        output special_data,
        output i2c_done,
        input  init_done,
        input  special_ack,
        input  special_done,
        input  i2c_start,
        input  i2c_register,
        input  i2c_data,
        input  timeout_error
    );
endinterface

// File: rtl/i2c_command_scheduler.sv
// ----------------------------------------------------------------------------
// i2c_command_scheduler
//   Sequences every camera register write through the I2C transmitter. Holds
//   the fixed startup table and arbitrates it against run-time special write
//   requests (startup entries always win). One command is in flight at a
//   time; after the transmitter reports completion (or the command times
//   out) a settling gap of GapCycles idle cycles is inserted.
//
// Ports
//   clk    in  system clock, all logic on posedge
//   rst_n  in  asynchronous active-low reset
//   bus    master modport of i2c_command_scheduler_if (requests, status,
//          transmitter handshake); every output is driven from a register
// ----------------------------------------------------------------------------
module i2c_command_scheduler #(
    parameter int InitEntries   = 8,
    parameter int GapCycles     = 500,
    parameter int TimeoutCycles = 1000000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    i2c_command_scheduler_if.master        bus
);

    localparam int IdxW = $clog2(InitEntries + 1);
    localparam int ToW  = $clog2(TimeoutCycles + 1);
    localparam int GapW = (GapCycles > 0) ? $clog2(GapCycles + 1) : 1;
    // One counter serves both the WAIT_DONE timeout and the GAP length.
    localparam int CntW = (ToW > GapW) ? ToW : GapW;

    localparam logic [IdxW-1:0] IdxLast = IdxW'(InitEntries - 1);
    localparam logic [IdxW-1:0] IdxZero = {IdxW{1'b0}};
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
    localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] ToLast  = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] GapLast = CntW'((GapCycles > 0) ? (GapCycles - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Startup table: {register[7:0], data[15:0]}.
    function automatic logic [23:0] init_entry(input logic [IdxW-1:0] idx);
        logic [23:0] entry;
        case (32'(idx))
            32'd0:   entry = 24'h23_0033;
            32'd1:   entry = 24'h22_0033;
            32'd2:   entry = 24'h04_09FF;
            32'd3:   entry = 24'h03_077F;
            32'd4:   entry = 24'h01_0038;
            32'd5:   entry = 24'h20_0060;
            32'd6:   entry = 24'h1E_4146;
            32'd7:   entry = 24'h0A_8000;
            default: entry = 24'h00_0000;
        endcase
        return entry;
    endfunction

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            pend_q, pend_d;       // startup table still has entries to issue
    logic            idone_q, idone_d;
    logic            src_q, src_d;         // 1: command in flight is a special write
    logic            stale_q, stale_d;     // in-flight table entry was superseded by init_go
    logic [7:0]      reg_q, reg_d;
    logic [15:0]     data_q, data_d;
    logic            start_q, start_d;
    logic            ack_q, ack_d;
    logic            sdone_q, sdone_d;
    logic            to_q, to_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            pend_eff_s;
    logic [IdxW-1:0] idx_eff_s;
    logic [23:0]     entry_s;
    logic            finish_s;
    logic            timed_out_s;

    // Next-state logic: FSM transitions, counters and next output values.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        idone_d     = idone_q;
        src_d       = src_q;
        stale_d     = stale_q;
        reg_d       = reg_q;
        data_d      = data_q;
        start_d     = 1'b0;
        ack_d       = 1'b0;
        sdone_d     = 1'b0;
        to_d        = to_q;
        cnt_d       = cnt_q;
        finish_s    = 1'b0;
        timed_out_s = 1'b0;

        // An init_go arriving in IDLE must beat a simultaneous special request,
        // so it is folded into the arbitration of this very cycle.
        pend_eff_s = pend_q | bus.init_go;
        idx_eff_s  = bus.init_go ? IdxZero : idx_q;
        entry_s    = init_entry(idx_eff_s);

        case (state_q)
            ST_IDLE: begin
                cnt_d = CntZero;
                if (pend_eff_s) begin
                    reg_d   = entry_s[23:16];
                    data_d  = entry_s[15:0];
                    src_d   = 1'b0;
                    stale_d = 1'b0;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end else if (bus.special_req) begin
                    reg_d   = bus.special_register;
                    data_d  = bus.special_data;
                    src_d   = 1'b1;
                    stale_d = 1'b0;
                    start_d = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CntZero;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion wins over a timeout landing on the same cycle.
                if (bus.i2c_done) begin
                    finish_s = 1'b1;
                end else if (cnt_q == ToLast) begin
                    finish_s    = 1'b1;
                    timed_out_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            ST_GAP: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = CntZero;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion bookkeeping happens on the edge that leaves WAIT_DONE.
        if (finish_s) begin
            cnt_d   = CntZero;
            state_d = (GapCycles > 0) ? ST_GAP : ST_IDLE;
            if (timed_out_s) begin
                to_d = 1'b1;
            end else begin
                to_d = to_q;
            end
            if (src_q) begin
                sdone_d = 1'b1;
            end else if (!stale_q) begin
                // Timed-out entries advance too, so one bad write cannot stall startup.
                idx_d = idx_q + IdxOne;
                if (idx_q == IdxLast) begin
                    pend_d  = 1'b0;
                    idone_d = 1'b1;
                end else begin
                    pend_d  = pend_q;
                end
            end else begin
                idx_d = idx_q;
            end
        end else begin
            to_d = to_d;
        end

        // init_go overrides any same-edge index bookkeeping: the table restarts.
        if (bus.init_go) begin
            pend_d  = 1'b1;
            idx_d   = IdxZero;
            idone_d = 1'b0;
            if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
                stale_d = 1'b1;
            end else begin
                stale_d = stale_d;
            end
        end else begin
            pend_d = pend_d;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= IdxZero;
            pend_q  <= 1'b0;
            idone_q <= 1'b0;
            src_q   <= 1'b0;
            stale_q <= 1'b0;
            reg_q   <= 8'h00;
            data_q  <= 16'h0000;
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            sdone_q <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= CntZero;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            idone_q <= idone_d;
            src_q   <= src_d;
            stale_q <= stale_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            sdone_q <= sdone_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.init_done     = idone_q;
    assign bus.special_ack   = ack_q;
    assign bus.special_done  = sdone_q;
    assign bus.i2c_start     = start_q;
    assign bus.i2c_register  = reg_q;
    assign bus.i2c_data      = data_q;
    assign bus.timeout_error = to_q;

endmodule

// File: tb/tb_i2c_command_scheduler.sv
// ----------------------------------------------------------------------------
// tb_i2c_command_scheduler
//   dut_a: GapCycles=500, short timeout; startup table, arbitration, timeout
//          and asynchronous reset sequences.
//   dut_b: GapCycles=0; stray i2c_done and back-to-back special writes.
//   A transmitter model answers each i2c_start with i2c_done 200 cycles later.
//   Expected commands are queued when stimulus is driven and popped by a
//   monitor on every i2c_start.
// ----------------------------------------------------------------------------
module tb_i2c_command_scheduler;

    localparam int GAP_A = 500;
    localparam int TO_A  = 1500;
    localparam int DLY   = 200;
    localparam int SPC_A = 1 + 1 + DLY + GAP_A;   // IDLE + ISSUE + transmit + gap
    localparam int SPC_B = 1 + 1 + DLY;           // no gap

    typedef struct packed {
        logic [7:0]  r;
        logic [15:0] d;
    } cmd_t;

    typedef struct {
        logic [7:0]  r;
        logic [15:0] d;
        int          gap;     // expected start-to-start spacing, 0 = not checked
    } svec_t;

    logic clk = 1'b0;
    logic rst_na;
    logic rst_nb;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_command_scheduler_if ifa ();
    i2c_command_scheduler_if ifb ();

    logic mdone_b = 1'b0;
    logic stray_b = 1'b0;
    assign ifb.i2c_done = mdone_b | stray_b;

    i2c_command_scheduler #(.InitEntries(8), .GapCycles(GAP_A), .TimeoutCycles(TO_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_na),
        .bus   (ifa)
    );

    i2c_command_scheduler #(.InitEntries(8), .GapCycles(0), .TimeoutCycles(1000)) dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (ifb)
    );

    cmd_t  init_tbl [8];
    svec_t svec [3];
    cmd_t  sb_a [$];
    cmd_t  sb_b [$];

    int   n_starts_a = 0, n_starts_b = 0;
    int   last_a = -1, last_b = -1;
    int   spacing_a = 0, spacing_b = 0;
    int   sdone_a = 0, sdone_b = 0, ack_b = 0;
    int   mcnt_a = 0, mcnt_b = 0;
    logic withhold_a = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] outs_a();
        return {3'b000, ifa.init_done, ifa.special_ack, ifa.special_done, ifa.i2c_start,
                ifa.timeout_error, ifa.i2c_register, ifa.i2c_data};
    endfunction

    function automatic logic [31:0] outs_b();
        return {3'b000, ifb.init_done, ifb.special_ack, ifb.special_done, ifb.i2c_start,
                ifb.timeout_error, ifb.i2c_register, ifb.i2c_data};
    endfunction

    // Transmitter model A: i2c_done 200 cycles after start unless withheld.
    initial begin
        ifa.i2c_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ifa.i2c_done = 1'b0;
            if (mcnt_a > 0) begin
                mcnt_a--;
                if (mcnt_a == 0) ifa.i2c_done = 1'b1;
            end
            if (ifa.i2c_start === 1'b1 && !withhold_a) mcnt_a = DLY;
            if (!rst_na) mcnt_a = 0;
        end
    end

    // Transmitter model B.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mdone_b = 1'b0;
            if (mcnt_b > 0) begin
                mcnt_b--;
                if (mcnt_b == 0) mdone_b = 1'b1;
            end
            if (ifb.i2c_start === 1'b1) mcnt_b = DLY;
            if (!rst_nb) mcnt_b = 0;
        end
    end

    // Monitor A: scoreboard pop on every start, spacing and pulse counts.
    initial begin
        cmd_t exp_c;
        forever begin
            @(negedge clk);
            if (ifa.i2c_start === 1'b1) begin
                n_starts_a++;
                check("a_start_expected", 32'(sb_a.size() != 0), 32'd1);
                if (sb_a.size() != 0) begin
                    exp_c = sb_a.pop_front();
                    check("a_cmd", {8'h00, ifa.i2c_register, ifa.i2c_data}, {8'h00, exp_c});
                end
                if (spacing_a != 0 && last_a >= 0) check("a_spacing", cyc - last_a, spacing_a);
                last_a = cyc;
            end
            if (ifa.special_done === 1'b1) sdone_a++;
        end
    end

    // Monitor B.
    initial begin
        cmd_t exp_c;
        forever begin
            @(negedge clk);
            if (ifb.i2c_start === 1'b1) begin
                n_starts_b++;
                check("b_start_expected", 32'(sb_b.size() != 0), 32'd1);
                if (sb_b.size() != 0) begin
                    exp_c = sb_b.pop_front();
                    check("b_cmd", {8'h00, ifb.i2c_register, ifb.i2c_data}, {8'h00, exp_c});
                end
                if (spacing_b != 0 && last_b >= 0) check("b_spacing", cyc - last_b, spacing_b);
                last_b = cyc;
            end
            if (ifb.special_done === 1'b1) sdone_b++;
            if (ifb.special_ack === 1'b1) ack_b++;
        end
    end

    task automatic pulse_init_a();
        ifa.init_go = 1'b1;
        @(negedge clk);
        ifa.init_go = 1'b0;
    endtask

    task automatic push_table_a();
        for (int i = 0; i < 8; i++) sb_a.push_back(init_tbl[i]);
    endtask

    task automatic wait_starts_a(input int n, input int bound);
        int k = 0;
        while (n_starts_a < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("a_wait_starts", 32'(n_starts_a >= n), 32'd1);
    endtask

    task automatic wait_init_done_a(input int bound);
        int k = 0;
        while (ifa.init_done !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("a_init_done", 32'(ifa.init_done), 32'd1);
    endtask

    task automatic special_a(input logic [7:0] r, input logic [15:0] d, input logic with_init, input int bound);
        int k = 0;
        ifa.special_register = r;
        ifa.special_data     = d;
        ifa.special_req      = 1'b1;
        ifa.init_go          = with_init;
        do begin
            @(negedge clk);
            ifa.init_go = 1'b0;
            k++;
        end while (ifa.special_ack !== 1'b1 && k < bound);
        check("a_ack_seen", 32'(ifa.special_ack), 32'd1);
        ifa.special_req      = 1'b0;
        ifa.special_register = ~r;
        ifa.special_data     = ~d;
    endtask

    task automatic special_b(input logic [7:0] r, input logic [15:0] d, input int bound);
        int k = 0;
        ifb.special_register = r;
        ifb.special_data     = d;
        ifb.special_req      = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (ifb.special_ack !== 1'b1 && k < bound);
        check("b_ack_seen", 32'(ifb.special_ack), 32'd1);
        ifb.special_req      = 1'b0;
        ifb.special_register = ~r;
        ifb.special_data     = ~d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t_to;
        init_tbl = '{'{8'h23, 16'h0033}, '{8'h22, 16'h0033}, '{8'h04, 16'h09FF}, '{8'h03, 16'h077F},
                     '{8'h01, 16'h0038}, '{8'h20, 16'h0060}, '{8'h1E, 16'h4146}, '{8'h0A, 16'h8000}};
        svec[0] = '{r: 8'h11, d: 16'hA5A5, gap: 0};
        svec[1] = '{r: 8'h5A, d: 16'h0F0F, gap: SPC_B};
        svec[2] = '{r: 8'hC3, d: 16'h8001, gap: SPC_B};

        rst_na = 1'b0;
        rst_nb = 1'b0;
        ifa.init_go = 1'b0; ifa.special_req = 1'b0; ifa.special_register = 8'h00; ifa.special_data = 16'h0000;
        ifb.init_go = 1'b0; ifb.special_req = 1'b0; ifb.special_register = 8'h00; ifb.special_data = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        check("a_reset_outputs", outs_a(), 32'd0);
        check("b_reset_outputs", outs_b(), 32'd0);
        rst_na = 1'b1;
        rst_nb = 1'b1;
        @(negedge clk);

        // 1: full startup table, fixed spacing, init_done after the 8th entry.
        base = n_starts_a;
        push_table_a();
        last_a = -1;
        spacing_a = SPC_A;
        pulse_init_a();
        wait_starts_a(base + 8, 8 * 800);
        check("a_init_done_before_last", 32'(ifa.init_done), 32'd0);
        wait_init_done_a(400);
        check("a_sb_empty_t1", sb_a.size(), 32'd0);
        repeat (600) @(negedge clk);

        // 2: special request during entry 2 waits for the whole table.
        base = n_starts_a;
        push_table_a();
        sb_a.push_back('{8'h05, 16'h1234});
        last_a = -1;
        sdone_a = 0;
        pulse_init_a();
        check("a_init_done_cleared", 32'(ifa.init_done), 32'd0);
        wait_starts_a(base + 3, 3 * 800);
        special_a(8'h05, 16'h1234, 1'b0, 8000);
        check("a_ack_after_table", 32'(ifa.init_done), 32'd1);
        repeat (300) @(negedge clk);
        check("a_sdone_once", sdone_a, 32'd1);
        check("a_sb_empty_t2", sb_a.size(), 32'd0);
        repeat (600) @(negedge clk);

        // 3: init_go and special_req on the same cycle: table first.
        push_table_a();
        sb_a.push_back('{8'h3C, 16'hBEEF});
        last_a = -1;
        special_a(8'h3C, 16'hBEEF, 1'b1, 8000);
        check("a_t3_ack_after_table", 32'(ifa.init_done), 32'd1);
        repeat (300) @(negedge clk);
        check("a_sb_empty_t3", sb_a.size(), 32'd0);
        repeat (600) @(negedge clk);

        // 4: entry 0 never completes: timeout, index still advances.
        base = n_starts_a;
        withhold_a = 1'b1;
        spacing_a = 0;
        last_a = -1;
        push_table_a();
        pulse_init_a();
        wait_starts_a(base + 1, 20);
        withhold_a = 1'b0;
        begin
            int k = 0;
            while (ifa.timeout_error !== 1'b1 && k < TO_A + 50) begin
                @(negedge clk);
                k++;
            end
        end
        t_to = cyc;
        check("a_timeout_seen", 32'(ifa.timeout_error), 32'd1);
        check("a_timeout_latency", t_to - last_a, TO_A + 1);
        wait_starts_a(base + 2, GAP_A + 100);
        check("a_gap_after_timeout", last_a - t_to, GAP_A + 1);
        wait_init_done_a(8 * 800);
        check("a_timeout_sticky", 32'(ifa.timeout_error), 32'd1);
        check("a_sb_empty_t4", sb_a.size(), 32'd0);
        repeat (600) @(negedge clk);

        // 5: reset during WAIT_DONE of entry 3, then restart from entry 0.
        base = n_starts_a;
        push_table_a();
        last_a = -1;
        spacing_a = SPC_A;
        pulse_init_a();
        wait_starts_a(base + 4, 4 * 800);
        repeat (50) @(negedge clk);
        rst_na = 1'b0;
        #1;
        check("a_async_reset_outputs", outs_a(), 32'd0);
        sb_a.delete();
        repeat (3) @(negedge clk);
        rst_na = 1'b1;
        repeat (2) @(negedge clk);
        push_table_a();
        last_a = -1;
        pulse_init_a();
        wait_init_done_a(8 * 800);
        check("a_sb_empty_t5", sb_a.size(), 32'd0);

        // 6: no gap; stray i2c_done in IDLE, then back-to-back special writes.
        stray_b = 1'b1;
        @(negedge clk);
        stray_b = 1'b0;
        repeat (20) @(negedge clk);
        check("b_stray_no_start", n_starts_b, 32'd0);
        check("b_stray_no_timeout", 32'(ifb.timeout_error), 32'd0);
        for (int i = 0; i < 3; i++) begin
            spacing_b = svec[i].gap;
            sb_b.push_back('{svec[i].r, svec[i].d});
            special_b(svec[i].r, svec[i].d, 400);
        end
        // A request withdrawn before it could be accepted gets no ack.
        ifb.special_register = 8'h77;
        ifb.special_req = 1'b1;
        repeat (50) @(negedge clk);
        ifb.special_req = 1'b0;
        repeat (300) @(negedge clk);
        check("b_ack_count", ack_b, 32'd3);
        check("b_sdone_count", sdone_b, 32'd3);
        check("b_reg_hold", {8'h00, ifb.i2c_register, ifb.i2c_data}, {8'h00, svec[2].r, svec[2].d});
        check("b_sb_empty", sb_b.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
